alu_arbiter: RTL

- Shares one alu instance between two requesters (REQ0, REQ1).
- Round-robin grant, captures the granted request's op_code and two 8-bit operands, then sequences the ALU: BEGIN pulse, operand X on inbus, operand Y on inbus.
- Collects the two result words the ALU pushes on outbus before END and returns a 16-bit response tagged with requester id.
- Watchdog aborts hung operations via an ALU clear pulse.

---
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the response port and the ALU sequencing port.
// The arbiter uses the slave view; whoever drives requests and models the ALU uses master.
interface alu_arbiter_if;
  logic        req0;
  logic [1:0]  op0;
  logic [7:0]  x0;
  logic [7:0]  y0;
  logic        ack0;
  logic        req1;
  logic [1:0]  op1;
  logic [7:0]  x1;
  logic [7:0]  y1;
  logic        ack1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_end;
  logic        alu_clear;
  logic        busy;

  modport slave (
    input  req0, op0, x0, y0, req1, op1, x1, y1, alu_outbus, alu_end,
    output ack0, ack1, rsp_valid, rsp_id, rsp_data, rsp_err,
           alu_begin, alu_op_code, alu_inbus, alu_clear, busy
  );

  modport master (
    output req0, op0, x0, y0, req1, op1, x1, y1, alu_outbus, alu_end,
    input  ack0, ack1, rsp_valid, rsp_id, rsp_data, rsp_err,
           alu_begin, alu_op_code, alu_inbus, alu_clear, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a watchdog that aborts
// operations whose END never arrives. Every output is a register.
module alu_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BEGIN  = 3'd1;
  localparam logic [2:0] S_LOAD_X = 3'd2;
  localparam logic [2:0] S_LOAD_Y = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic [7:0]       s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             begin_q, begin_d, clear_q, clear_d, busy_q, busy_d;
  logic [1:0]       opc_q, opc_d;
  logic [7:0]       inbus_q, inbus_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             gnt;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    wd_d         = wd_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    clear_d      = 1'b0;
    gnt          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester that did not win last time gets the ALU
          gnt          = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          last_grant_d = gnt;
          owner_d      = gnt;
          op_d         = gnt ? bus.op1 : bus.op0;
          x_d          = gnt ? bus.x1 : bus.x0;
          y_d          = gnt ? bus.y1 : bus.y0;
          ack0_d       = ~gnt;
          ack1_d       = gnt;
          state_d      = S_BEGIN;
        end
      end
      S_BEGIN:  state_d = S_LOAD_X;
      S_LOAD_X: state_d = S_LOAD_Y;
      S_LOAD_Y: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Two-deep history of outbus: the result words precede END by two and one cycles
        s2_d = s1_q;
        s1_d = bus.alu_outbus;
        wd_d = wd_q + 1'b1;
        if (bus.alu_end) begin
          rsp_data_d = {s2_q, s1_q};
          rsp_err_d  = 1'b0;
          rsp_id_d   = owner_q;
          state_d    = S_RESP;
        end else if (wd_q == WD_LAST) begin
          clear_d    = 1'b1;
          rsp_data_d = 16'h0000;
          rsp_err_d  = 1'b1;
          rsp_id_d   = owner_q;
          state_d    = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    begin_d     = (state_d == S_BEGIN);
    rsp_valid_d = (state_d == S_RESP);
    opc_d       = (state_d == S_IDLE) ? 2'b00 : op_d;
    inbus_d     = (state_d == S_LOAD_X) ? x_d :
                  (state_d == S_LOAD_Y) ? y_d : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 2'b00;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      s1_q         <= 8'h00;
      s2_q         <= 8'h00;
      wd_q         <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      begin_q      <= 1'b0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      opc_q        <= 2'b00;
      inbus_q      <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      x_q          <= x_d;
      y_q          <= y_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      wd_q         <= wd_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      begin_q      <= begin_d;
      clear_q      <= clear_d;
      busy_q       <= busy_d;
      opc_q        <= opc_d;
      inbus_q      <= inbus_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.alu_begin   = begin_q;
  assign bus.alu_op_code = opc_q;
  assign bus.alu_inbus   = inbus_q;
  assign bus.alu_clear   = clear_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
endmodule
